fetch_stage: RTL

Instruction-fetch stage that sits directly downstream of `pc_control`. It consumes `nextPC` and issues request/acknowledge fetches to instruction memory. It delivers `{instruction, pc}` to the decode stage through a valid/stall output register. It also generates the `stall` that holds `pc_control`, and squashes in-flight or buffered fetches when a branch or jump redirects the PC.

---
 rtl/fetch_stage.sv | 104 ++++++++++
 1 files changed

// File: rtl/fetch_stage.sv
// Instruction fetch: one outstanding imem request, a one-entry hold buffer, and a valid/stall output register.
// Latency 2 edges launch-to-output with zero-wait memory; pc_stall holds pc_control whenever no launch/redirect occurs.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP      = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] nextPC,
  input  logic        redirect,
  input  logic        stall,
  output logic        pc_stall,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        if_valid,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc
);

  typedef enum logic [1:0] {IDLE, REQ, HOLD} state_t;

  state_t      state;
  logic        squash;
  logic [63:0] hold_buf;   // {instr, pc}
  logic        ack;
  logic        slot_free;
  logic        launch;

  always_comb begin
    ack       = imem_req && imem_ack;
    slot_free = !if_valid || !stall;
    launch    = 1'b0;
    if (!redirect) begin
      case (state)
        IDLE:    launch = 1'b1;
        REQ:     launch = ack && !squash && slot_free;
        HOLD:    launch = slot_free;
        default: launch = 1'b0;
      endcase
    end
    pc_stall = !reset || !(launch || redirect);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      squash    <= 1'b0;
      hold_buf  <= 64'h0;
      imem_req  <= 1'b0;
      imem_addr <= RESET_PC;
      if_valid  <= 1'b0;
      if_instr  <= NOP;
      if_pc     <= RESET_PC;
    end else if (redirect) begin
      if_valid <= 1'b0;
      if_instr <= NOP;
      if (state == REQ && !ack) begin
        // Memory still owes us a word; stay in REQ and drop it on arrival.
        squash <= 1'b1;
      end else begin
        squash   <= 1'b0;
        imem_req <= 1'b0;
        state    <= IDLE;
      end
    end else begin
      if (if_valid && !stall) if_valid <= 1'b0;
      if (launch) begin
        imem_req  <= 1'b1;
        imem_addr <= nextPC;
        state     <= REQ;
      end
      case (state)
        REQ: begin
          if (ack) begin
            if (squash) begin
              squash   <= 1'b0;
              imem_req <= 1'b0;
              state    <= IDLE;
            end else if (slot_free) begin
              if_instr <= imem_rdata;
              if_pc    <= imem_addr;
              if_valid <= 1'b1;
            end else begin
              hold_buf <= {imem_rdata, imem_addr};
              imem_req <= 1'b0;
              state    <= HOLD;
            end
          end
        end
        HOLD: begin
          if (slot_free) begin
            if_instr <= hold_buf[63:32];
            if_pc    <= hold_buf[31:0];
            if_valid <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
